hangman_engine: RTL and testbench
=================================

Name: hangman_engine

Overview:
Parametrised next-generation hangman game core. Word length, character width and miss budget are generic. The word ROM is external and accessed through an address/data pair. Each guess reveals every matching position in a single check, and repeated guesses are detected and cost no try. The block sits under the user project wrapper and drives the game-status IO directly.

Parameters:
WORD_LEN, 5, letters per word (1..8)
CHAR_W, 5, bits per character (1..6); guessed-letter map is 2**CHAR_W bits
MAX_TRIES, 7, misses allowed before loss (>=1)
ADDR_W, 6, word ROM address width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high
next  input  1  level button; only rising edges are acted on
guess_char  input  CHAR_W  letter sampled on a next rising edge in GUESS
word_sel  input  ADDR_W  word index sampled on a next rising edge in IDLE
word_addr  output  ADDR_W  registered ROM address
word_data  input  WORD_LEN*CHAR_W  combinational ROM data; position i = bits [(i+1)*CHAR_W-1 : i*CHAR_W]
revealed  output  WORD_LEN  bit i set = position i guessed
tries_left  output  $clog2(MAX_TRIES+1)  MAX_TRIES minus misses
hit  output  1  1-cycle pulse: guess revealed >=1 new position
miss  output  1  1-cycle pulse: guess cost a try
repeat_guess  output  1  1-cycle pulse: letter already guessed, no penalty
win  output  1  game won, held until IDLE
lose  output  1  game lost, held until IDLE
busy  output  1  high in FETCH and CHECK

Behaviour:
- Reset: synchronous, active-high, overrides everything including mid-game.
  - state=IDLE; word_addr=0; revealed=0; misses=0; guessed map=0.
  - hit/miss/repeat_guess/win/lose/busy=0; tries_left=MAX_TRIES; next_q=0.
- Edge detect: next_rise = next & ~next_q, with next_q registered every cycle. Holding next high produces exactly one event.
- States and transitions:
  - IDLE: on next_rise, word_addr<=word_sel; clear revealed, misses and guessed map; go to FETCH.
  - FETCH (1 cycle): word_q<=word_data; go to GUESS.
  - GUESS: on next_rise, guess_q<=guess_char; go to CHECK. Otherwise hold.
  - CHECK (1 cycle), with match[i] = (word_q slice i == guess_q):
    - If guessed_map[guess_q]=1: pulse repeat_guess; no other state change; go to GUESS.
    - Else set guessed_map[guess_q]:
      - match!=0: revealed<=revealed|match; pulse hit. If (revealed|match) is all ones, set win and go to WIN; else go to GUESS.
      - match==0: misses<=misses+1; pulse miss. If misses+1==MAX_TRIES, set lose and go to LOSE; else go to GUESS.
  - WIN / LOSE: hold win or lose and keep revealed. On next_rise, clear win/lose and go to IDLE.
- Guesses are only accepted in GUESS; next edges in CHECK are ignored.
- Latency: next_rise in GUESS at cycle t → CHECK at t+1 → revealed, tries_left, pulses, win and lose valid at t+2. Pulses deassert at t+3.
- misses saturates at MAX_TRIES and never wraps. tries_left = MAX_TRIES - misses.
- guess_char and word_data are sampled only as stated; changes at other times have no effect.
- Every output is a register, except tries_left, which is derived from the misses register.

Test Plan:
(All with WORD_LEN=5, CHAR_W=5, MAX_TRIES=7, A=0. ROM[3] = L,E,V,E,L = {11,4,21,4,11}, position 4 first.)
- Reset, word_sel=3, pulse next → word_addr=3, busy high for 1 cycle, state reaches GUESS; revealed=0, tries_left=7.
- Guess E(4) → revealed=5'b01010, hit for 1 cycle at t+2; guess E again → repeat_guess, revealed and tries_left unchanged.
- Continue with L(11) then V(21) → revealed=5'b11011, then 5'b11111; win=1 at t+2 of the V guess, held. Next pulse → IDLE with win=0.
- New game, 7 distinct wrong letters (0,1,2,3,5,6,7) → tries_left steps 6..0; lose=1 after the 7th; revealed unchanged. A repeated wrong letter before the 7th gives repeat_guess with no decrement.
- Hold next high for 20 cycles in GUESS → exactly one CHECK, one pulse.
- Assert reset for 1 cycle mid-game (revealed=01010, tries_left=5) → next cycle all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/hangman_engine.sv
// Hangman game core: fetches a word from an external ROM, then checks one
// guessed letter per next edge against every position at once.
module hangman_engine #(
  parameter int WORD_LEN  = 5,
  parameter int CHAR_W    = 5,
  parameter int MAX_TRIES = 7,
  parameter int ADDR_W    = 6
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             next,
  input  logic [CHAR_W-1:0]                guess_char,
  input  logic [ADDR_W-1:0]                word_sel,
  output logic [ADDR_W-1:0]                word_addr,
  input  logic [WORD_LEN*CHAR_W-1:0]       word_data,
  output logic [WORD_LEN-1:0]              revealed,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
  output logic                             hit,
  output logic                             miss,
  output logic                             repeat_guess,
  output logic                             win,
  output logic                             lose,
  output logic                             busy
);

  localparam int TW    = $clog2(MAX_TRIES + 1);
  localparam int MAP_W = 2 ** CHAR_W;

  typedef enum logic [2:0] {IDLE, FETCH, GUESS, CHECK, WIN, LOSE} state_t;

  state_t                       state;
  logic                         next_q;
  logic                         next_rise;
  logic [WORD_LEN*CHAR_W-1:0]   word_q;
  logic [CHAR_W-1:0]            guess_q;
  logic [MAP_W-1:0]             guessed_map;
  logic [TW-1:0]                misses;
  logic [TW-1:0]                misses_inc;
  logic [WORD_LEN-1:0]          match;
  logic [WORD_LEN-1:0]          revealed_nx;
  logic                         already;

  assign next_rise   = next & ~next_q;
  assign misses_inc  = misses + TW'(1);
  assign tries_left  = TW'(MAX_TRIES) - misses;
  assign already     = guessed_map[guess_q];
  assign revealed_nx = revealed | match;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < WORD_LEN; i++)
      match[i] = (word_q[i*CHAR_W +: CHAR_W] == guess_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      next_q       <= 1'b0;
      word_addr    <= '0;
      word_q       <= '0;
      guess_q      <= '0;
      guessed_map  <= '0;
      misses       <= '0;
      revealed     <= '0;
      hit          <= 1'b0;
      miss         <= 1'b0;
      repeat_guess <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      next_q       <= next;
      hit          <= 1'b0;
      miss         <= 1'b0;
      repeat_guess <= 1'b0;
      case (state)
        IDLE: if (next_rise) begin
          word_addr   <= word_sel;
          revealed    <= '0;
          misses      <= '0;
          guessed_map <= '0;
          busy        <= 1'b1;
          state       <= FETCH;
        end
        FETCH: begin
          word_q <= word_data;
          busy   <= 1'b0;
          state  <= GUESS;
        end
        GUESS: if (next_rise) begin
          guess_q <= guess_char;
          busy    <= 1'b1;
          state   <= CHECK;
        end
        CHECK: begin
          busy <= 1'b0;
          if (already) begin
            repeat_guess <= 1'b1;
            state        <= GUESS;
          end else begin
            guessed_map[guess_q] <= 1'b1;
            if (|match) begin
              revealed <= revealed_nx;
              hit      <= 1'b1;
              if (&revealed_nx) begin
                win   <= 1'b1;
                state <= WIN;
              end else begin
                state <= GUESS;
              end
            end else begin
              // Guard keeps misses from wrapping even if the loss exit is bypassed.
              if (misses != TW'(MAX_TRIES)) misses <= misses_inc;
              miss <= 1'b1;
              if (misses_inc == TW'(MAX_TRIES)) begin
                lose  <= 1'b1;
                state <= LOSE;
              end else begin
                state <= GUESS;
              end
            end
          end
        end
        WIN, LOSE: if (next_rise) begin
          win   <= 1'b0;
          lose  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hangman_engine.sv
// Self-checking bench for hangman_engine: directed game scenarios plus
// randomized play, compared each cycle against a set-based game model.
module tb_hangman_engine;

  localparam int WL = 5;
  localparam int CW = 5;
  localparam int MAXT = 7;
  localparam int AW = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             next = 1'b0;
  logic [CW-1:0]    guess_char = '0;
  logic [AW-1:0]    word_sel = '0;
  logic [AW-1:0]    word_addr;
  logic [WL*CW-1:0] word_data;
  logic [WL-1:0]    revealed;
  logic [2:0]       tries_left;
  logic             hit, miss, repeat_guess, win, lose, busy;

  logic [WL*CW-1:0] rom [64];
  assign word_data = rom[word_addr];

  hangman_engine #(.WORD_LEN(WL), .CHAR_W(CW), .MAX_TRIES(MAXT), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .next(next), .guess_char(guess_char),
    .word_sel(word_sel), .word_addr(word_addr), .word_data(word_data),
    .revealed(revealed), .tries_left(tries_left), .hit(hit), .miss(miss),
    .repeat_guess(repeat_guess), .win(win), .lose(lose), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Game model: a word, the set of letters tried, a count of wrong letters.
  // Revealed positions are simply those whose letter is in the tried set.
  typedef enum int {P_IDLE, P_FETCH, P_GUESS, P_CHECK, P_WIN, P_LOSE} phase_t;
  phase_t           m_phase;
  logic             m_ok = 1'b0;
  logic             m_nq;
  logic [AW-1:0]    m_addr;
  logic [WL*CW-1:0] m_word;
  logic [CW-1:0]    m_g;
  logic [31:0]      m_tried;
  int               m_wrong;
  logic             m_hit, m_mp, m_rep, m_win, m_lose;

  function automatic logic [WL-1:0] shown(input logic [WL*CW-1:0] w, input logic [31:0] s);
    logic [WL-1:0] r;
    for (int i = 0; i < WL; i++) r[i] = s[w[i*CW +: CW]];
    return r;
  endfunction

  function automatic int occurrences(input logic [WL*CW-1:0] w, input logic [CW-1:0] c);
    int n = 0;
    for (int i = 0; i < WL; i++) if (w[i*CW +: CW] == c) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ok <= 1'b1; m_phase <= P_IDLE; m_nq <= 1'b0; m_addr <= '0; m_word <= '0;
      m_g <= '0; m_tried <= '0; m_wrong <= 0;
      m_hit <= 1'b0; m_mp <= 1'b0; m_rep <= 1'b0; m_win <= 1'b0; m_lose <= 1'b0;
    end else begin
      m_nq <= next; m_hit <= 1'b0; m_mp <= 1'b0; m_rep <= 1'b0;
      case (m_phase)
        P_IDLE: if (next && !m_nq) begin
          m_addr <= word_sel; m_tried <= '0; m_wrong <= 0; m_phase <= P_FETCH;
        end
        P_FETCH: begin m_word <= rom[m_addr]; m_phase <= P_GUESS; end
        P_GUESS: if (next && !m_nq) begin m_g <= guess_char; m_phase <= P_CHECK; end
        P_CHECK: begin
          if (m_tried[m_g]) begin
            m_rep <= 1'b1; m_phase <= P_GUESS;
          end else begin
            m_tried[m_g] <= 1'b1;
            if (occurrences(m_word, m_g) > 0) begin
              m_hit <= 1'b1;
              if (&shown(m_word, m_tried | (32'd1 << m_g))) begin
                m_win <= 1'b1; m_phase <= P_WIN;
              end else m_phase <= P_GUESS;
            end else begin
              m_mp <= 1'b1; m_wrong <= m_wrong + 1;
              if (m_wrong + 1 >= MAXT) begin m_lose <= 1'b1; m_phase <= P_LOSE; end
              else m_phase <= P_GUESS;
            end
          end
        end
        default: if (next && !m_nq) begin
          m_win <= 1'b0; m_lose <= 1'b0; m_phase <= P_IDLE;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("word_addr", int'(word_addr), int'(m_addr));
      check("revealed", int'(revealed), int'(shown(m_word, m_tried)));
      check("tries_left", int'(tries_left), MAXT - m_wrong);
      check("hit", int'(hit), int'(m_hit));
      check("miss", int'(miss), int'(m_mp));
      check("repeat_guess", int'(repeat_guess), int'(m_rep));
      check("win", int'(win), int'(m_win));
      check("lose", int'(lose), int'(m_lose));
      check("busy", int'(busy), int'(m_phase == P_FETCH || m_phase == P_CHECK));
    end
  end

  task automatic pulse_next();
    @(negedge clk) next = 1'b1;
    @(negedge clk) next = 1'b0;
  endtask

  // Leaves the bench one negedge after the result of the guess is visible.
  task automatic do_guess(input logic [CW-1:0] c);
    guess_char = c;
    pulse_next();
    guess_char = CW'($urandom);
    @(negedge clk);
  endtask

  task automatic start_game(input logic [AW-1:0] s);
    word_sel = s;
    pulse_next();
    word_sel = AW'($urandom);
    @(negedge clk);
  endtask

  int pulses;
  int wrong_letters [7] = '{0, 1, 2, 3, 5, 6, 7};

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = (WL*CW)'({$urandom, $urandom});
    rom[3] = {5'd11, 5'd4, 5'd21, 5'd4, 5'd11};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_revealed", int'(revealed), 0);
    check("rst_tries", int'(tries_left), 7);
    check("rst_busy", int'(busy), 0);

    word_sel = 6'd3;
    pulse_next();
    check("fetch_busy", int'(busy), 1);
    check("fetch_addr", int'(word_addr), 3);
    @(negedge clk);
    check("guess_busy", int'(busy), 0);
    check("start_revealed", int'(revealed), 0);

    do_guess(5'd4);
    check("E_revealed", int'(revealed), 5'b01010);
    check("E_hit", int'(hit), 1);
    @(negedge clk);
    check("E_hit_drop", int'(hit), 0);
    do_guess(5'd4);
    check("E_repeat", int'(repeat_guess), 1);
    check("E_rep_tries", int'(tries_left), 7);
    do_guess(5'd11);
    check("L_revealed", int'(revealed), 5'b11011);
    do_guess(5'd21);
    check("V_revealed", int'(revealed), 5'b11111);
    check("V_win", int'(win), 1);
    repeat (5) @(negedge clk);
    check("win_held", int'(win), 1);
    pulse_next();
    check("win_clear", int'(win), 0);

    start_game(6'd3);
    for (int k = 0; k < 7; k++) begin
      do_guess(CW'(wrong_letters[k]));
      check("wrong_tries", int'(tries_left), 6 - k);
      if (k == 2) begin
        do_guess(5'd0);
        check("wrong_repeat", int'(repeat_guess), 1);
        check("wrong_rep_tries", int'(tries_left), 4);
      end
    end
    check("lose_set", int'(lose), 1);
    check("lose_revealed", int'(revealed), 0);
    pulse_next();
    check("lose_clear", int'(lose), 0);

    start_game(6'd3);
    guess_char = 5'd4;
    @(negedge clk) next = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      pulses += int'(hit) + int'(miss) + int'(repeat_guess);
    end
    next = 1'b0;
    check("hold_pulses", pulses, 1);
    @(negedge clk);
    do_guess(5'd0);
    do_guess(5'd1);
    check("pre_rst_revealed", int'(revealed), 5'b01010);
    check("pre_rst_tries", int'(tries_left), 5);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("mid_rst_revealed", int'(revealed), 0);
    check("mid_rst_tries", int'(tries_left), 7);
    check("mid_rst_addr", int'(word_addr), 0);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 499) == 0);
      next = ($urandom_range(0, 2) == 0);
      word_sel = ($urandom_range(0, 3) == 0) ? 6'd3 : AW'($urandom);
      if ($urandom_range(0, 1) == 0) guess_char = m_word[$urandom_range(0, WL-1)*CW +: CW];
      else guess_char = CW'($urandom);
    end
    reset = 1'b0;
    next = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
